// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate type and FSM state encoding for the
// 640x480@60 raster generator.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic {
        ARM = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;

    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;

    localparam coord_t H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam coord_t V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the sprite
// and compositor stages.
interface vga_timing_gen_if;

    vga_timing_pkg::coord_t DrawX;
    vga_timing_pkg::coord_t DrawY;
    logic                   blank;
    logic                   hs;
    logic                   vs;
    logic                   frame_start;

    modport master (
        output DrawX,
        output DrawY,
        output blank,
        output hs,
        output vs,
        output frame_start
    );

    modport slave (
        input DrawX,
        input DrawY,
        input blank,
        input hs,
        input vs,
        input frame_start
    );

endinterface

// File: rtl/sync_delay_line.sv
// Single-bit shift register of configurable depth with an async active-low
// reset to RST_VAL; DEPTH of 0 degenerates to a wire.
module sync_delay_line #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_sr
            logic [DEPTH-1:0] sr_q;
            logic [DEPTH-1:0] sr_d;

            always_comb begin
                sr_d    = sr_q;
                sr_d[0] = d;
                for (int i = 1; i < DEPTH; i++) begin
                    sr_d[i] = sr_q[i-1];
                end
            end

            always_ff @(posedge clk_sys or negedge rst_b) begin
                if (!rst_b) begin
                    sr_q <= {DEPTH{RST_VAL}};
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign q = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing source: DrawX/DrawY, blank, hs/vs and frame strobe.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by SYNC_DELAY pixel clocks.
//
// state | meaning
// ARM   | first clock after reset: hold (0,0) and load its decode
// RUN   | free-running raster scan until the next reset
module vga_timing_gen
    import vga_timing_pkg::*;
(
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vga
);

`ifdef VGA_SYNC_DELAY_EN
    parameter int SYNC_DELAY = 2;
`endif

    state_t state_q, state_d;
    coord_t hc_q, hc_d;
    coord_t vc_q, vc_d;
    logic   blank_q, blank_d;
    logic   hs_q, hs_d;
    logic   vs_q, vs_d;
    logic   fs_q, fs_d;
    logic   hs_out;
    logic   vs_out;

    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        vc_d    = vc_q;
        case (state_q)
            ARM: begin
                hc_d    = '0;
                vc_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                if (hc_q == H_TOTAL - 10'd1) begin
                    hc_d = '0;
                    vc_d = (vc_q == V_TOTAL - 10'd1) ? '0 : vc_q + 10'd1;
                end else begin
                    hc_d = hc_q + 10'd1;
                end
            end
            default: state_d = ARM;
        endcase

        // Decode from the next count so every output lines up with DrawX/DrawY.
        blank_d = (hc_d < H_VISIBLE) && (vc_d < V_VISIBLE);
        hs_d    = !((hc_d >= H_SYNC_START) && (hc_d < H_SYNC_END));
        vs_d    = !((vc_d >= V_SYNC_START) && (vc_d < V_SYNC_END));
        fs_d    = (hc_d == '0) && (vc_d == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARM;
            hc_q    <= '0;
            vc_q    <= '0;
            blank_q <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (1'b1)
    ) u_hs_dly (
        .clk_sys (vga_clk),
        .rst_b   (reset_n),
        .d       (hs_q),
        .q       (hs_out)
    );

    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .RST_VAL (1'b1)
    ) u_vs_dly (
        .clk_sys (vga_clk),
        .rst_b   (reset_n),
        .d       (vs_q),
        .q       (vs_out)
    );
`else
    assign hs_out = hs_q;
    assign vs_out = vs_q;
`endif

    assign vga.DrawX       = hc_q;
    assign vga.DrawY       = vc_q;
    assign vga.blank       = blank_q;
    assign vga.hs          = hs_out;
    assign vga.vs          = vs_out;
    assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: cycle scoreboard against a
// time-indexed raster model plus sync/blank/frame boundary monitors.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    localparam logic [23:0] RST_VEC = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

    logic vga_clk = 1'b0;
    logic reset_n = 1'b1;

    vga_timing_gen_if vif ();

    vga_timing_gen dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vga     (vif)
    );

    always #20 vga_clk = ~vga_clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] observed();
        return {vif.DrawX, vif.DrawY, vif.blank, vif.hs, vif.vs, vif.frame_start};
    endfunction

    // Expected outputs t clocks after the ARM edge (t=0 is the ARM edge).
    function automatic logic [23:0] model(input int t);
        int  x, y, td, xd, yd;
        logic hs_e, vs_e;
        x = t % 800;
        y = (t / 800) % 525;
        if (t < SD) begin
            hs_e = 1'b1;
            vs_e = 1'b1;
        end else begin
            td   = t - SD;
            xd   = td % 800;
            yd   = (td / 800) % 525;
            hs_e = !(xd >= 656 && xd < 752);
            vs_e = !(yd >= 490 && yd < 492);
        end
        return {10'(x), 10'(y), 1'(x < 640 && y < 480), hs_e, vs_e, 1'(x == 0 && y == 0)};
    endfunction

    logic [23:0] sb[$];
    int          t_mod = 0;

    always @(posedge vga_clk) begin
        if (!reset_n) begin
            t_mod = 0;
            sb.push_back(RST_VEC);
        end else begin
            sb.push_back(model(t_mod));
            t_mod++;
        end
    end

    int   cyc, fs_last, fs_cnt, hs_low, vs_low, prev_x, prev_y;
    bit   fs_seen, line_seen, prev_ok;
    logic prev_hs, prev_vs;
    logic [23:0] exp_vec;

    always @(negedge vga_clk) begin
        if (sb.size() != 0) begin
            exp_vec = sb.pop_front();
            chk("px", 32'(observed()), 32'(exp_vec));
        end
        if (!reset_n) begin
            cyc = 0; fs_last = 0; fs_cnt = 0; hs_low = 0; vs_low = 0;
            fs_seen = 0; line_seen = 0; prev_ok = 0;
            prev_hs = 1'b1; prev_vs = 1'b1;
        end else begin
            if (vif.frame_start) begin
                if (fs_seen) begin
                    chk("fs_gap", cyc - fs_last, 420000);
                    chk("vs_low_cnt", vs_low, 1600);
                end
                fs_seen = 1; fs_last = cyc; vs_low = 0; fs_cnt++;
            end
            if (vif.DrawX == 10'd0) begin
                if (line_seen) chk("hs_low_cnt", hs_low, 96);
                line_seen = 1; hs_low = 0;
            end
            if (!vif.hs) hs_low++;
            if (!vif.vs) vs_low++;
            if (prev_hs && !vif.hs) chk("hs_fall_x", vif.DrawX, 656 + SD);
            if (!prev_hs && vif.hs) chk("hs_rise_x", vif.DrawX, 752 + SD);
            if (prev_vs && !vif.vs) chk("vs_fall_xy", {vif.DrawY, vif.DrawX}, {10'd490, 10'(SD)});
            if (!prev_vs && vif.vs) chk("vs_rise_xy", {vif.DrawY, vif.DrawX}, {10'd492, 10'(SD)});
            if (prev_ok && prev_x == 799) chk("wrap_xy", {vif.DrawY, vif.DrawX}, {10'((prev_y + 1) % 525), 10'd0});
            if (vif.DrawX == 10'd640 && vif.DrawY == 10'd0)   chk("blank_640_0", vif.blank, 0);
            if (vif.DrawX == 10'd799 && vif.DrawY == 10'd100) chk("blank_799_100", vif.blank, 0);
            if (vif.DrawX == 10'd0   && vif.DrawY == 10'd480) chk("blank_0_480", vif.blank, 0);
            if (vif.DrawX == 10'd639 && vif.DrawY == 10'd479) chk("blank_639_479", vif.blank, 1);
            if (vif.DrawX == 10'd0   && vif.DrawY == 10'd0)   chk("blank_0_0", vif.blank, 1);
            prev_hs = vif.hs; prev_vs = vif.vs;
            prev_x = int'(vif.DrawX); prev_y = int'(vif.DrawY); prev_ok = 1;
            cyc++;
        end
    end

    task automatic arm_checks();
        @(posedge vga_clk); #1;
        chk("arm_x", vif.DrawX, 0);
        chk("arm_y", vif.DrawY, 0);
        chk("arm_blank", vif.blank, 1);
        chk("arm_fs", vif.frame_start, 1);
        @(posedge vga_clk); #1;
        chk("run1_x", vif.DrawX, 1);
        chk("run1_fs", vif.frame_start, 0);
    endtask

    initial begin
        bit found;
        #1 reset_n = 1'b0;
        #60;
        chk("rst_vec", 32'(observed()), 32'(RST_VEC));
        @(negedge vga_clk); #5 reset_n = 1'b1;
        arm_checks();

        found = 0;
        for (int i = 0; i < 200000 && !found; i++) begin
            @(negedge vga_clk); #1;
            if (vif.DrawX == 10'd300 && vif.DrawY == 10'd200) found = 1;
        end
        chk("reach_300_200", found, 1);

        #4 reset_n = 1'b0;
        #1;
        chk("async_rst", 32'(observed()), 32'(RST_VEC));
        repeat (3) @(negedge vga_clk);
        #5 reset_n = 1'b1;
        arm_checks();

        found = 0;
        for (int i = 0; i < 430000 && !found; i++) begin
            @(negedge vga_clk); #1;
            if (fs_cnt >= 2) found = 1;
        end
        chk("second_frame", found, 1);
        repeat (900) @(negedge vga_clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing source for the display path.
- Generates the DrawX/DrawY scan coordinates and the blank qualifier consumed by every sprite renderer (ROM + palette stages).
- Also generates the hs/vs sync pulses and a per-frame strobe for game logic.
- Fixed mode is 640x480 at 60 Hz on the 25 MHz pixel clock. Sits directly upstream of the sprite/compositor stages.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 2, pipeline depth of downstream pixel path; used only with VGA_SYNC_DELAY_EN

Ports:
- vga_clk  input  1  pixel clock, 25 MHz
- reset_n  input  1  asynchronous, active-low reset
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = visible pixel (display enabled), 0 = blanking
- hs  output  1  horizontal sync, active-low
- vs  output  1  vertical sync, active-low
- frame_start  output  1  one-cycle pulse at pixel (0,0)

Interface: one clock, vga_clk; reset is asynchronous and active-low, reset_n.

Behaviour:
- Derived constants: H_TOTAL = sum of H terms = 800; V_TOTAL = sum of V terms = 525. Both must fit in 10 bits; counters are 10-bit unsigned.
- Reset values (reset_n low, asynchronous): DrawX=0, DrawY=0, blank=0, hs=1, vs=1, frame_start=0, FSM=ARM.
- FSM state ARM: entered only from reset.
  - On the first vga_clk edge with reset_n high, counters hold at (0,0) and all decoded outputs load the decode of (0,0): blank=1, frame_start=1.
  - Next state RUN.
- FSM state RUN:
  - Each edge, hc=hc+1.
  - When hc==H_TOTAL-1: hc wraps to 0 and vc=vc+1.
  - When vc==V_TOTAL-1 at a line wrap: vc wraps to 0.
  - Remains in RUN until reset.
- Output decode:
  - All outputs are registered. hs/vs/blank/frame_start are decoded from the next-state counter value, so they align with DrawX/DrawY in the same cycle (zero relative latency).
  - blank = (DrawX < H_VISIBLE) && (DrawY < V_VISIBLE).
  - hs = 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - vs = 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491, for every pixel of those lines.
  - frame_start = 1 iff next (hc,vc) == (0,0).
- Periods:
  - Line period is exactly 800 cycles.
  - Frame period is exactly 420000 cycles.
  - frame_start spacing is exactly 420000 cycles, including the first frame after ARM.
- Reset asserted mid-frame: all outputs return immediately to reset values. After release, the block re-enters ARM and restarts at (0,0); no partial-line residue.

Optional Feature:
- Macro VGA_SYNC_DELAY_EN.
- Defined:
  - hs and vs are each passed through a SYNC_DELAY-stage shift register, reset value 1, so sync edges line up with the downstream pixel colour. Downstream latency is ROM read (1) plus output register (1), hence the default of 2.
  - DrawX, DrawY, blank and frame_start are not delayed.
  - SYNC_DELAY=0 is legal and means pass-through.
- Undefined: no delay logic is built, SYNC_DELAY is ignored, and hs/vs align with DrawX/DrawY.

Decomposition:
- Package vga_timing_pkg holds:
  - the timing constants (visible/porch/sync values and the derived H_TOTAL and V_TOTAL, 800 and 525);
  - the 10-bit coordinate typedef;
  - the FSM state enum {ARM, RUN}.
- One natural sub-module, sync_delay_line: a parameterised-depth single-bit shift register with async active-low reset and a reset value parameter. It is instantiated twice under VGA_SYNC_DELAY_EN.

Test Plan:
- Reset release → next edge shows DrawX=0, DrawY=0, blank=1, frame_start=1; the following edge shows DrawX=1, frame_start=0.
- Free-run one line → hs low exactly for DrawX 656..751 (96 cycles); DrawX wraps 799→0 with DrawY incrementing.
- Free-run one frame → vs low for DrawY 490..491 (1600 cycles); the next frame_start arrives 420000 cycles after the first.
- Sample blank → 0 at (640,0), (799,100) and (0,480); 1 at (639,479) and (0,0).
- With VGA_SYNC_DELAY_EN, SYNC_DELAY=2 → hs falls 2 cycles after DrawX==656 and rises 2 cycles after DrawX==752; vs delayed likewise.
- Assert reset_n low at DrawX=300, DrawY=200 → outputs go to reset values without waiting for a clock edge; after release, ARM and then a full 420000-cycle frame.
